dual_bit_serializer: RTL and testbench
======================================

// Module: dual_bit_serializer
// PURPOSE
//  Upstream feeder for the dual enabled-flop capture stage (d_1/d_2/en -> q = q_1 & q_2).
//  Accepts two parallel words through a valid/ready handshake and shifts them out
//  LSB-first, one bit per lane per enable strobe.
//  Strobe period is programmable, so the capture stage samples each bit exactly once.
// PARAMETERS
//  WORD_W  8  bits per lane per transfer; legal range >= 1
//  DIV     1  clocks per enable strobe; legal range >= 1
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       upstream word pair valid
//  in_ready   out  1       block can accept a word pair
//  in_word_a  in   WORD_W  lane-A word, drives d_1
//  in_word_b  in   WORD_W  lane-B word, drives d_2
//  en         out  1       one-cycle capture strobe to downstream flops
//  d_1        out  1       lane-A serial bit
//  d_2        out  1       lane-B serial bit
//  busy       out  1       transfer in progress (SHIFT or DONE)
//  done       out  1       one-cycle pulse after the last strobe
// BEHAVIOUR
//  - All outputs are registered, except in_ready and busy, which decode the FSM state.
//  - Reset values: state=IDLE, in_ready=1, en=0, d_1=0, d_2=0, busy=0, done=0.
//    Shift regs, bit_cnt and div_cnt are all 0.
//  - Counters: bit_cnt is max(1,$clog2(WORD_W)) bits wide;
//    div_cnt is max(1,$clog2(DIV)) bits wide.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&in_ready: load sh_a=in_word_a and sh_b=in_word_b.
//    - d_1<=in_word_a[0], d_2<=in_word_b[0], bit_cnt<=0, div_cnt<=0, go to SHIFT.
//  - SHIFT:
//    - in_ready=0, and in_valid is ignored.
//    - div_cnt increments each cycle. When div_cnt==DIV-1: en<=1 and div_cnt<=0.
//      Otherwise en<=0.
//    - The cycle after each strobe, shift both regs right by one.
//      d_1/d_2 take the new bit[0] and hold it stable until the next strobe.
//    - On the strobe with bit_cnt==WORD_W-1: go to DONE. No further shift.
//  - DONE:
//    - done=1 for exactly one cycle; en=0; d_1/d_2 are cleared to 0.
//    - Next state is IDLE.
//  - Timing: handshake accepted at edge T.
//    - en is high in cycles T+DIV, T+2*DIV, ... T+WORD_W*DIV (WORD_W strobes total).
//    - done is high in cycle T+WORD_W*DIV+1.
//    - in_ready is high again at T+WORD_W*DIV+2.
//  - Each strobe presents bit k of both words, k = 0..WORD_W-1.
//    d_1/d_2 are stable for one full cycle before and during en.
//  - DIV=1: en is high on every SHIFT cycle, WORD_W consecutive cycles.
//  - WORD_W=1: a single strobe, then DONE.
//  - Back-to-back transfers: minimum gap of 2 cycles (DONE, IDLE) between
//    the last strobe and the next accept. No word is ever dropped.
//  - rst mid-transfer: on the next edge, return to IDLE with all reset values.
//    en is never asserted in the reset cycle or the cycle after it.
//    The partial word is discarded.
//  - in_valid with X data while not ready: no effect.
// TESTING
//  1. Reset hold 3 cycles -> in_ready=1; en, d_1, d_2, busy and done all 0.
//  2. WORD_W=8, DIV=1, a=8'hA5, b=8'h3C:
//     - en high 8 consecutive cycles.
//     - d_1 = 1,0,1,0,0,1,0,1 and d_2 = 0,0,1,1,1,1,0,0.
//     - done pulses 1 cycle later.
//     - Downstream q sequence equals the bitwise AND of the two lanes.
//  3. WORD_W=8, DIV=3, a=8'hFF, b=8'h81:
//     - en every 3rd cycle, 8 strobes total; first strobe 3 cycles after accept.
//     - d_2 is 1 only at strobes 0 and 7.
//  4. in_valid held high for 3 word pairs:
//     - each pair is accepted exactly once, gap of 2 cycles between transfers.
//     - in_ready stays 0 throughout SHIFT.
//  5. rst asserted after strobe 4 of 8:
//     - next cycle: IDLE, in_ready=1, no further en, no done pulse.
//     - A new transfer then completes normally.
//  6. WORD_W=1, DIV=1, a=1, b=1:
//     - en for 1 cycle with d_1=d_2=1; done on the next cycle.

Source files
------------

// File: rtl/dual_bit_serializer_if.sv
// Word-pair handshake bundle between an upstream producer and the serializer.
//   in_valid   producer -> serializer   word pair valid
//   in_ready   serializer -> producer   serializer can take a pair this cycle
//   in_word_a  producer -> serializer   lane-A word (feeds d_1)
//   in_word_b  producer -> serializer   lane-B word (feeds d_2)
interface dual_bit_serializer_if #(
  parameter int WORD_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word_a;
  logic [WORD_W-1:0] in_word_b;

  modport master (output in_valid, output in_word_a, output in_word_b, input in_ready);
  modport slave  (input in_valid, input in_word_a, input in_word_b, output in_ready);
endinterface

// File: rtl/dual_bit_serializer.sv
// Dual-lane LSB-first serializer feeding a pair of enabled capture flops.
// A word pair taken over the handshake is shifted out one bit per lane per
// en strobe; strobes are spaced DIV clocks apart.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   word-pair handshake (slave side)
//   en    one-cycle capture strobe (registered)
//   d_1   lane-A serial bit (registered)
//   d_2   lane-B serial bit (registered)
//   busy  transfer in progress, SHIFT or DONE (state decode)
//   done  one-cycle pulse the cycle after the last strobe (registered)
module dual_bit_serializer #(
  parameter int WORD_W = 8,
  parameter int DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_bit_serializer_if.slave  bus,
  output logic                  en,
  output logic                  d_1,
  output logic                  d_2,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] sh_a, sh_b, sh_a_nx, sh_b_nx;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              ready, tick, last;

  assign sh_a_nx = sh_a >> 1;
  assign sh_b_nx = sh_b >> 1;
  assign tick    = (div_cnt == DIV_LAST);
  // en is the registered strobe, so this is true during the final strobe cycle;
  // the FSM leaves SHIFT on the edge that ends it.
  assign last    = en && (bit_cnt == BIT_LAST);
  assign bus.in_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      en      <= 1'b0;
      d_1     <= 1'b0;
      d_2     <= 1'b0;
      done    <= 1'b0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh_a    <= bus.in_word_a;
            sh_b    <= bus.in_word_b;
            d_1     <= bus.in_word_a[0];
            d_2     <= bus.in_word_b[0];
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (last) begin
            done <= 1'b1;
            d_1  <= 1'b0;
            d_2  <= 1'b0;
          end else begin
            en      <= tick;
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            // Advance to the next bit on the edge closing a strobe cycle so
            // the new bit settles ahead of the following strobe.
            if (en) begin
              sh_a    <= sh_a_nx;
              sh_b    <= sh_b_nx;
              d_1     <= sh_a_nx[0];
              d_2     <= sh_b_nx[0];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dual_bit_serializer.sv
module tb_dual_bit_serializer;
  logic clk, rst;
  logic tb_valid;
  logic [7:0] tb_a, tb_b;
  int sel;
  int n_cmp, n_err;

  dual_bit_serializer_if #(.WORD_W(8)) if8 ();
  dual_bit_serializer_if #(.WORD_W(8)) if3 ();
  dual_bit_serializer_if #(.WORD_W(1)) if1 ();

  assign if8.in_valid  = tb_valid && (sel == 0);
  assign if8.in_word_a = tb_a;
  assign if8.in_word_b = tb_b;
  assign if3.in_valid  = tb_valid && (sel == 1);
  assign if3.in_word_a = tb_a;
  assign if3.in_word_b = tb_b;
  assign if1.in_valid  = tb_valid && (sel == 2);
  assign if1.in_word_a = tb_a[0:0];
  assign if1.in_word_b = tb_b[0:0];

  logic en8, d18, d28, busy8, done8;
  logic en3, d13, d23, busy3, done3;
  logic en1, d11, d21, busy1, done1;

  dual_bit_serializer #(.WORD_W(8), .DIV(1)) u8 (
    .clk(clk), .rst(rst), .bus(if8.slave),
    .en(en8), .d_1(d18), .d_2(d28), .busy(busy8), .done(done8));
  dual_bit_serializer #(.WORD_W(8), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .bus(if3.slave),
    .en(en3), .d_1(d13), .d_2(d23), .busy(busy3), .done(done3));
  dual_bit_serializer #(.WORD_W(1), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .en(en1), .d_1(d11), .d_2(d21), .busy(busy1), .done(done1));

  // Selected instance view
  logic en_s, d1_s, d2_s, busy_s, done_s, ready_s;
  always_comb begin
    en_s = en1; d1_s = d11; d2_s = d21; busy_s = busy1; done_s = done1; ready_s = if1.in_ready;
    case (sel)
      0: begin en_s = en8; d1_s = d18; d2_s = d28; busy_s = busy8; done_s = done8; ready_s = if8.in_ready; end
      1: begin en_s = en3; d1_s = d13; d2_s = d23; busy_s = busy3; done_s = done3; ready_s = if3.in_ready; end
      default: ;
    endcase
  end

  // Downstream capture-stage model: q = q_1 & q_2
  logic q1, q2;
  always_ff @(posedge clk) begin
    if (en_s) begin
      q1 <= d1_s;
      q2 <= d2_s;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer on instance s with cycle-by-cycle expectations.
  task automatic xfer(input int s, input logic [7:0] a, input logic [7:0] b,
                      input int w, input int dv);
    int  lst, k, pk, kp;
    bit  stb, pstb;
    sel = s;
    @(negedge clk);
    tb_a = a; tb_b = b; tb_valid = 1'b1;
    chk("ready_pre", ready_s, 1);
    @(negedge clk);
    tb_valid = 1'b0;
    lst = w * dv; pstb = 0; pk = 0;
    for (int n = 0; n <= lst + 2; n++) begin
      stb = (n >= dv) && (n <= lst) && (n % dv == 0);
      k = n / dv - 1;
      chk("en", en_s, stb);
      chk("done", done_s, n == lst + 1);
      chk("ready", ready_s, n >= lst + 2);
      chk("busy", busy_s, n < lst + 2);
      if (stb) begin
        chk("d_1", d1_s, a[k]);
        chk("d_2", d2_s, b[k]);
      end
      if (dv > 1 && (n + 1) >= dv && (n + 1) <= lst && ((n + 1) % dv == 0)) begin
        kp = (n + 1) / dv - 1;
        chk("d_1_pre", d1_s, a[kp]);
        chk("d_2_pre", d2_s, b[kp]);
      end
      if (n == lst + 1) begin
        chk("d_1_clr", d1_s, 0);
        chk("d_2_clr", d2_s, 0);
      end
      if (pstb) chk("q", q1 & q2, a[pk] & b[pk]);
      pstb = stb; pk = k;
      @(negedge clk);
    end
  endtask

  logic [7:0] pa [3];
  logic [7:0] pb [3];
  logic [7:0] ga [3];
  logic [7:0] gb [3];
  int acc_c [3];

  initial begin
    int i, nb, cyc, ns, seen, rdy_hi;
    bit acc;
    n_cmp = 0; n_err = 0;
    sel = 0; tb_valid = 1'b0; tb_a = '0; tb_b = '0;

    // 1. reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_s, 1);
    chk("rst_en", en_s, 0);
    chk("rst_d_1", d1_s, 0);
    chk("rst_d_2", d2_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    rst = 1'b0;

    // 2. DIV=1
    xfer(0, 8'hA5, 8'h3C, 8, 1);
    // 3. DIV=3
    xfer(1, 8'hFF, 8'h81, 8, 3);

    // 4. back-to-back with in_valid held high
    pa[0] = 8'h12; pb[0] = 8'h34;
    pa[1] = 8'hC3; pb[1] = 8'h5A;
    pa[2] = 8'h0F; pb[2] = 8'hF0;
    ga[0] = '0; ga[1] = '0; ga[2] = '0; gb[0] = '0; gb[1] = '0; gb[2] = '0;
    acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
    sel = 0;
    @(negedge clk);
    tb_a = pa[0]; tb_b = pb[0]; tb_valid = 1'b1;
    i = 0; nb = 0; cyc = 0; rdy_hi = 0;
    while (cyc < 80 && (i < 3 || nb < 24)) begin
      if (en_s) begin
        if (nb < 24) begin
          ga[nb / 8][nb % 8] = d1_s;
          gb[nb / 8][nb % 8] = d2_s;
        end
        nb++;
      end
      if (ready_s && tb_valid) rdy_hi++;
      acc = tb_valid && ready_s;
      if (acc) begin
        if (i < 3) acc_c[i] = cyc;
        i++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (i < 3) begin tb_a = pa[i]; tb_b = pb[i]; end
        else tb_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tb_valid = 1'b0;
    chk("b2b_accepts", i, 3);
    chk("b2b_ready_hi", rdy_hi, 3);
    chk("b2b_strobes", nb, 24);
    chk("b2b_gap01", acc_c[1] - acc_c[0], 11);
    chk("b2b_gap12", acc_c[2] - acc_c[1], 11);
    for (int p = 0; p < 3; p++) begin
      chk("b2b_word_a", ga[p], pa[p]);
      chk("b2b_word_b", gb[p], pb[p]);
    end
    repeat (4) @(negedge clk);

    // 5. reset after strobe 4 of 8 (DIV=3)
    sel = 1;
    @(negedge clk);
    tb_a = 8'hFF; tb_b = 8'h81; tb_valid = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
    ns = 0;
    for (int c = 0; c < 40 && ns < 4; c++) begin
      if (en_s) ns++;
      @(negedge clk);
    end
    chk("mid_strobes", ns, 4);
    chk("mid_busy", busy_s, 1);
    rst = 1'b1;
    chk("rstcyc_en", en_s, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", ready_s, 1);
    chk("mid_en", en_s, 0);
    chk("mid_d_1", d1_s, 0);
    chk("mid_d_2", d2_s, 0);
    chk("mid_busy_clr", busy_s, 0);
    chk("mid_done", done_s, 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (en_s || done_s || busy_s) seen++;
      @(negedge clk);
    end
    chk("mid_quiet", seen, 0);
    xfer(1, 8'h6B, 8'hD2, 8, 3);

    // 6. WORD_W=1
    xfer(2, 8'h01, 8'h01, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
